// File: rtl/cp0_exc_sequencer_pkg.sv
// Shared CP0 select codes, FSM encodings and default handler address for the exception sequencer.
// The macros are visible to every later file of the block; the package mirrors them as typed constants.
`ifndef CP0_EXC_SEQUENCER_DEFS
`define CP0_EXC_SEQUENCER_DEFS
`define CP0_SEL_SR      2'd0
`define CP0_SEL_CAS     2'd1
`define CP0_SEL_EPC     2'd2
`define CP0_SEL_PRID    2'd3
`define CP0_ST_IDLE     3'd0
`define CP0_ST_DRAIN    3'd1
`define CP0_ST_ENTER    3'd2
`define CP0_ST_REDIRECT 3'd3
`define CP0_ST_ERET     3'd4
`define CP0_HANDLER_PC  30'h0000_1060
`endif

package cp0_exc_sequencer_pkg;
  localparam logic [1:0]  SEL_SR          = `CP0_SEL_SR;
  localparam logic [1:0]  SEL_CAS         = `CP0_SEL_CAS;
  localparam logic [1:0]  SEL_EPC         = `CP0_SEL_EPC;
  localparam logic [1:0]  SEL_PRID        = `CP0_SEL_PRID;
  localparam logic [29:0] DEF_HANDLER_PC  = `CP0_HANDLER_PC;
  localparam logic [4:0]  CP0_RD_FIRST    = 5'd12;
endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// Commit-stage / CP0 / fetch-control signal bundle of the exception sequencer.
// master drives the commit-side inputs, slave is the sequencer itself.
interface cp0_exc_sequencer_if;
  logic        int_req;
  logic [29:0] epc;
  logic        inst_valid;
  logic [29:0] commit_pc;
  logic        is_eret;
  logic        is_mtc0;
  logic        is_mfc0;
  logic [4:0]  cp0_rd;
  logic        pipe_empty;
  logic [1:0]  cp0_sel;
  logic        cp0_wen;
  logic        exl_set;
  logic        exl_clr;
  logic [29:0] cp0_pc;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        illegal_cp0;

  modport master (
    output int_req, epc, inst_valid, commit_pc, is_eret, is_mtc0, is_mfc0, cp0_rd, pipe_empty,
    input  cp0_sel, cp0_wen, exl_set, exl_clr, cp0_pc, stall, flush, redirect, redirect_pc,
           illegal_cp0
  );

  modport slave (
    input  int_req, epc, inst_valid, commit_pc, is_eret, is_mtc0, is_mfc0, cp0_rd, pipe_empty,
    output cp0_sel, cp0_wen, exl_set, exl_clr, cp0_pc, stall, flush, redirect, redirect_pc,
           illegal_cp0
  );
endinterface

// File: rtl/cp0_exc_sequencer_sel_decode.sv
// Combinational CP0 register decode: {valid, rd} -> {sel, legal}; zero latency.
// Only rd 12..15 (SR, Cause, EPC, PRID) map; anything else reports illegal and selects SR.
module cp0_sel_decode
  import cp0_exc_sequencer_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] rd,
  output logic [1:0] sel,
  output logic       legal
);
  always_comb begin
    sel   = SEL_SR;
    legal = 1'b0;
    if (valid && (rd[4:2] == CP0_RD_FIRST[4:2])) begin
      legal = 1'b1;
      sel   = rd[1:0];
    end
  end
endmodule

// File: rtl/cp0_exc_sequencer.sv
// CP0 port arbiter and interrupt/eret sequencer: interrupt reaches redirect DRAIN_CYCLES+2 cycles after
// acceptance while pipe_empty holds; pipe_empty=0 stretches DRAIN, eret redirects one cycle after commit.
module cp0_exc_sequencer
  import cp0_exc_sequencer_pkg::*;
#(
  parameter logic [29:0] HANDLER_PC   = `CP0_HANDLER_PC,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_exc_sequencer_if.slave   bus
);
  localparam logic [2:0] IDLE       = `CP0_ST_IDLE;
  localparam logic [2:0] DRAIN      = `CP0_ST_DRAIN;
  localparam logic [2:0] ENTER      = `CP0_ST_ENTER;
  localparam logic [2:0] REDIRECT   = `CP0_ST_REDIRECT;
  localparam logic [2:0] ERET       = `CP0_ST_ERET;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [29:0] pc_q;
  logic        cp0_op;
  logic        dec_legal;
  logic [1:0]  dec_sel;
  logic        in_idle;
  logic        int_take;
  logic        eret_take;
  logic        drain_done;

  assign cp0_op     = bus.inst_valid & (bus.is_mtc0 | bus.is_mfc0);
  assign in_idle    = (state_q == IDLE);
  assign int_take   = in_idle & bus.int_req;
  assign eret_take  = in_idle & ~bus.int_req & bus.inst_valid & bus.is_eret;
  assign drain_done = (cnt_q >= DRAIN_LAST) & bus.pipe_empty;

  cp0_sel_decode u_sel_decode (
    .valid (cp0_op),
    .rd    (bus.cp0_rd),
    .sel   (dec_sel),
    .legal (dec_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (int_take)       state_d = DRAIN;
        else if (eret_take) state_d = ERET;
      end
      DRAIN:    if (drain_done) state_d = ENTER;
      ENTER:    state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      ERET:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 30'd0;
    end else begin
      state_q <= state_d;
      if (int_take) pc_q <= bus.commit_pc;
      // Counter restarts on every DRAIN entry and saturates so a long drain cannot wrap past the threshold.
      if (state_q != DRAIN)                   cnt_q <= 4'd0;
      else if (!drain_done && cnt_q != 4'hf)  cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bus.cp0_pc = pc_q;

  // Outputs are forced quiet while reset is held, independent of the live inputs.
  always_comb begin
    bus.cp0_sel     = SEL_SR;
    bus.cp0_wen     = 1'b0;
    bus.exl_set     = 1'b0;
    bus.exl_clr     = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = HANDLER_PC;
    bus.illegal_cp0 = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (bus.int_req) begin
            bus.stall = 1'b1;
            bus.flush = 1'b1;
          end else if (bus.inst_valid && bus.is_eret) begin
            bus.flush   = 1'b1;
            bus.exl_clr = 1'b1;
          end else if (cp0_op) begin
            if (dec_legal) begin
              bus.cp0_sel = dec_sel;
              bus.cp0_wen = bus.is_mtc0;
            end else begin
              bus.illegal_cp0 = 1'b1;
            end
          end
        end
        DRAIN: bus.stall = 1'b1;
        ENTER: begin
          bus.stall   = 1'b1;
          bus.exl_set = 1'b1;
        end
        REDIRECT: begin
          bus.stall    = 1'b1;
          bus.redirect = 1'b1;
        end
        ERET: begin
          bus.stall       = 1'b1;
          bus.redirect    = 1'b1;
          bus.redirect_pc = bus.epc;
        end
        default: ;
      endcase
    end
  end
endmodule
